// File: rtl/pipeline_trace_buffer.sv
// rtl/pipeline_trace_buffer.sv - retirement trace buffer with free-run, stop-when-full and triggered capture
module pipeline_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       retire_valid,
  input  logic [DATA_W-1:0]          retire_pc,
  input  logic [REG_W-1:0]           retire_rd,
  input  logic                       retire_we,
  input  logic [DATA_W-1:0]          retire_result,
  input  logic [1:0]                 mode,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       trig_in,
  input  logic                       trig_pc_en,
  input  logic [DATA_W-1:0]          trig_pc,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_pc,
  output logic [REG_W-1:0]           rd_rd,
  output logic                       rd_we,
  output logic [DATA_W-1:0]          rd_result,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       capturing,
  output logic                       triggered,
  output logic                       done,
  output logic                       overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_STOP = 2'b01;
  localparam logic [1:0] MODE_TRIG = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_POST, S_DONE} state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   post_cnt;

  logic [DATA_W-1:0] mem_pc     [DEPTH];
  logic [REG_W-1:0]  mem_rd     [DEPTH];
  logic              mem_we     [DEPTH];
  logic [DATA_W-1:0] mem_result [DEPTH];

  logic active;
  logic full;
  logic wr_en;
  logic trig_hit;
  logic pop;

  always_comb begin
    active   = (state == S_CAPTURE) || (state == S_POST);
    full     = (count == CW'(DEPTH));
    // Stop-when-full leaves CAPTURE on the filling write, so the guard only matters defensively
    wr_en    = active && retire_valid && !arm && !(full && (mode_q == MODE_STOP));
    trig_hit = (mode_q == MODE_TRIG) && (state == S_CAPTURE) && retire_valid &&
               (trig_in || (trig_pc_en && (retire_pc == trig_pc)));
    pop      = ((state == S_IDLE) || (state == S_DONE)) && rd_req && (count != '0) && !arm;
  end

  assign empty     = (count == '0);
  assign capturing = active;
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr]     <= retire_pc;
      mem_rd[wr_ptr]     <= retire_rd;
      mem_we[wr_ptr]     <= retire_we;
      mem_result[wr_ptr] <= retire_result;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      mode_q    <= MODE_FREE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_pc     <= '0;
      rd_rd     <= '0;
      rd_we     <= 1'b0;
      rd_result <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (arm) begin
        state     <= S_CAPTURE;
        mode_q    <= (mode == 2'b11) ? MODE_FREE : mode;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        post_cnt  <= '0;
        triggered <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (full) begin
            rd_ptr   <= rd_ptr + 1'b1;
            overflow <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end

        if (pop) begin
          rd_valid  <= 1'b1;
          rd_pc     <= mem_pc[rd_ptr];
          rd_rd     <= mem_rd[rd_ptr];
          rd_we     <= mem_we[rd_ptr];
          rd_result <= mem_result[rd_ptr];
          rd_ptr    <= rd_ptr + 1'b1;
          count     <= count - 1'b1;
        end

        if (trig_hit) begin
          triggered <= 1'b1;
          post_cnt  <= CW'(POST_TRIG);
        end

        case (state)
          S_CAPTURE: begin
            if (stop) begin
              state <= S_DONE;
            end else if (trig_hit) begin
              state <= (POST_TRIG == 0) ? S_DONE : S_POST;
            end else if (wr_en && (mode_q == MODE_STOP) && (count == CW'(DEPTH - 1))) begin
              state <= S_DONE;
            end
          end
          S_POST: begin
            if (wr_en) begin
              post_cnt <= post_cnt - 1'b1;
            end
            if (stop || (wr_en && (post_cnt == CW'(1)))) begin
              state <= S_DONE;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
